// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: FSM state encoding,
// baud divider helper and counter widths.
package uart_pkg;

  localparam int ERR_CNT_W = 8;
  localparam int CNT_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_e;

  function automatic int uart_div(input int freq_mhz, input int baud);
    return (freq_mhz * 1000000) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with wrap-bit pointers; a push while full is
// accepted only when a pop frees the head slot in the same cycle.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_level   = r_wr_ptr - r_rd_ptr;
  // Masked head keeps the output at 0 while empty instead of stale RAM.
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx_mon.sv
// UART receiver: 2-flop synchroniser, bit FSM, error pulses, saturating error
// counter and output FIFO. Even parity is compiled in by UART_RX_MON_PARITY_EN.
module uart_rx_mon
  import uart_pkg::*;
#(
  parameter int FREQ_MHZ   = 12,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLK_I,
  input  logic                          RST_N_I,
  input  logic                          RX_I,
  output logic [DATA_BITS-1:0]          DATA_O,
  output logic                          VALID_O,
  input  logic                          READY_I,
  output logic                          FRAME_ERR_O,
  output logic                          PARITY_ERR_O,
  output logic                          OVERRUN_O,
  output logic [ERR_CNT_W-1:0]          ERR_CNT_O,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL_O,
  output logic [2:0]                    DBG_STATE_O
);

  localparam int DIV = uart_div(FREQ_MHZ, BAUD);
  localparam logic [CNT_W-1:0] C_HALF     = CNT_W'(DIV/2 - 1);
  localparam logic [CNT_W-1:0] C_FULL     = CNT_W'(DIV - 1);
  localparam logic [3:0]       C_LAST_BIT = 4'(DATA_BITS - 1);

  if (DIV < 8) begin : g_div_chk
    $error("uart_rx_mon: clock/baud divider must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_chk
    $error("uart_rx_mon: DATA_BITS must be 5..9");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("uart_rx_mon: FIFO_DEPTH must be a power of two >= 2");
  end

  logic                 r_rx_s1, r_rx_s2, r_rx_d;
  logic [1:0]           r_sync_ok;
  state_e               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [3:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err;
  logic                 r_frame_err, r_parity_err, r_overrun;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 w_fall, w_tick, w_push, w_pop, w_full, w_empty;

  // r_rx_d stays 0 until the synchroniser holds real line samples, so a line
  // already low at reset release never looks like a falling edge.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_d    <= 1'b0;
      r_sync_ok <= 2'b00;
    end else begin
      r_rx_s1   <= RX_I;
      r_rx_s2   <= r_rx_s1;
      r_sync_ok <= {r_sync_ok[0], 1'b1};
      r_rx_d    <= r_sync_ok[1] ? r_rx_s2 : 1'b0;
    end
  end

  assign w_fall = r_rx_d & ~r_rx_s2;
  assign w_tick = (r_cnt == '0);
  assign w_push = (r_state == ST_STOP) & w_tick & r_rx_s2 & ~r_par_err;
  assign w_pop  = VALID_O & READY_I;

`ifdef UART_RX_MON_PARITY_EN
  logic w_par_bad;
  assign w_par_bad = (^r_shift) ^ r_rx_s2;
`endif

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_par_err    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
      case (r_state)
        ST_IDLE: if (w_fall) begin
          r_cnt   <= C_HALF;
          r_state <= ST_START;
        end
        ST_START: if (w_tick) begin
          if (r_rx_s2) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt     <= C_FULL;
            r_bit_idx <= '0;
            r_par_err <= 1'b0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: if (w_tick) begin
          r_shift <= {r_rx_s2, r_shift[DATA_BITS-1:1]};
          r_cnt   <= C_FULL;
          if (r_bit_idx == C_LAST_BIT) begin
`ifdef UART_RX_MON_PARITY_EN
            r_state <= ST_PARITY;
`else
            r_state <= ST_STOP;
`endif
          end else begin
            r_bit_idx <= r_bit_idx + 4'd1;
          end
        end
`ifdef UART_RX_MON_PARITY_EN
        ST_PARITY: if (w_tick) begin
          r_par_err    <= w_par_bad;
          r_parity_err <= w_par_bad;
          r_cnt        <= C_FULL;
          r_state      <= ST_STOP;
        end
`endif
        ST_STOP: if (w_tick) begin
          if (!r_rx_s2) begin
            r_frame_err <= 1'b1;
            r_state     <= ST_BREAK;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_BREAK: if (r_rx_s2) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Error events are counted one cycle after their pulse is registered.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_overrun <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_overrun <= w_push & w_full & ~w_pop;
      if ((r_frame_err | r_parity_err | r_overrun) && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (CLK_I),
    .i_rst_n     (RST_N_I),
    .i_push      (w_push),
    .i_push_data (r_shift),
    .i_pop       (w_pop),
    .o_data      (DATA_O),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (LEVEL_O)
  );

  assign VALID_O     = ~w_empty;
  assign FRAME_ERR_O = r_frame_err;
  assign OVERRUN_O   = r_overrun;
  assign ERR_CNT_O   = r_err_cnt;
  assign DBG_STATE_O = r_state;
`ifdef UART_RX_MON_PARITY_EN
  assign PARITY_ERR_O = r_parity_err;
`else
  assign PARITY_ERR_O = 1'b0;
`endif

endmodule
